dmd_fb_write_ctrl: RTL and testbench

//  Owns write port A of the dual-port DMD frame-buffer BRAM (13-bit addr, 4-bit pixel).

---
 rtl/dmd_fb_pkg.sv | 20 ++
 rtl/dmd_fb_addr_gen.sv | 37 +++
 rtl/dmd_fb_write_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dmd_fb_write_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmd_fb_pkg.sv
// Shared geometry, widths and FSM encoding for the DMD frame-buffer write controller.
package dmd_fb_pkg;

    localparam int H_PIX        = 128;
    localparam int V_PIX        = 32;
    localparam int PIX_W        = 4;
    localparam int ADDR_W       = 13;
    localparam int PIX_PER_PAGE = H_PIX * V_PIX;
    localparam int CNT_W        = ADDR_W - 1;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_PAGE - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        CLEAR     = 2'd2,
        SWAP_PEND = 2'd3
    } state_t;

endpackage

// File: rtl/dmd_fb_addr_gen.sv
// 12-bit pixel counter (clear / increment / load-1) and port-A address formation.
import dmd_fb_pkg::*;

module dmd_fb_addr_gen (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt_clr,
    input  logic              cnt_inc,
    input  logic              cnt_load1,
    input  logic              zero_sel,
    input  logic              back_page,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] addr
);

    logic [CNT_W-1:0] pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (cnt_clr) begin
            count <= '0;
        end else if (cnt_load1) begin
            count <= CNT_W'(1);
        end else if (cnt_inc) begin
            count <= count + 1'b1;
        end
    end

    // A start-of-frame beat targets pixel 0 regardless of where the counter stands.
    always_comb begin
        pix = zero_sel ? '0 : count;
    end

    assign addr = {back_page, pix};

endmodule

// File: rtl/dmd_fb_write_ctrl.sv
// Port-A write sequencer for the double-buffered DMD frame buffer (stream + fill engine).
// Optional statistics outputs are enabled by defining DMD_FB_STATS_EN.
import dmd_fb_pkg::*;

module dmd_fb_write_ctrl (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_sof,
    input  logic              clr_req,
    input  logic [PIX_W-1:0]  clr_value,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [PIX_W-1:0]  dina,
    output logic              front_page,
    output logic              busy,
    output logic              frame_done
`ifdef DMD_FB_STATS_EN
    ,
    output logic [15:0]       frames_done,
    output logic [15:0]       sof_errors
`endif
);

    state_t            state;
    logic [PIX_W-1:0]  clr_val;
    logic              back_page;
    logic              accept;
    logic              wr_en;
    logic              wr_zero;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_load1;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] wr_addr;

    assign back_page = ~front_page;

    dmd_fb_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .cnt_load1 (cnt_load1),
        .zero_sel  (wr_zero),
        .back_page (back_page),
        .count     (count),
        .addr      (wr_addr)
    );

    always_comb begin
        accept    = s_valid && s_ready;
        wr_en     = 1'b0;
        wr_zero   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_load1 = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    cnt_clr = 1'b1;
                end else if (accept && s_sof) begin
                    wr_en     = 1'b1;
                    wr_zero   = 1'b1;
                    cnt_load1 = 1'b1;
                end
            end
            STREAM: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (s_sof) begin
                        wr_zero   = 1'b1;
                        cnt_load1 = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                cnt_inc = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            front_page <= 1'b0;
            clr_val    <= '0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef DMD_FB_STATS_EN
            frames_done <= '0;
            sof_errors  <= '0;
`endif
        end else begin
            wea        <= wr_en;
            frame_done <= 1'b0;
            if (wr_en) begin
                addra <= wr_addr;
                dina  <= (state == CLEAR) ? clr_val : s_data;
            end
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_val <= clr_value;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                    end else if (accept && s_sof) begin
                        state   <= STREAM;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                STREAM: begin
                    if (accept && !s_sof && count == LAST_PIX) begin
                        state   <= SWAP_PEND;
                        s_ready <= 1'b0;
                    end
`ifdef DMD_FB_STATS_EN
                    if (accept && s_sof && sof_errors != '1) begin
                        sof_errors <= sof_errors + 1'b1;
                    end
`endif
                end
                CLEAR: begin
                    if (count == LAST_PIX) begin
                        state <= SWAP_PEND;
                    end
                end
                SWAP_PEND: begin
                    // wea is high only while the final write issues; a vsync then is too early.
                    if (vsync && !wea) begin
                        state      <= IDLE;
                        front_page <= ~front_page;
                        frame_done <= 1'b1;
                        s_ready    <= 1'b1;
                        busy       <= 1'b0;
`ifdef DMD_FB_STATS_EN
                        frames_done <= frames_done + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmd_fb_write_ctrl.sv
// Scoreboard bench for dmd_fb_write_ctrl: transaction-level model pushes expected writes,
// a negedge monitor pops and compares them along with the handshake/page outputs.
module tb_dmd_fb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  s_data = '0;
    logic        s_sof = 1'b0;
    logic        clr_req = 1'b0;
    logic [3:0]  clr_value = '0;
    logic        wea;
    logic [12:0] addra;
    logic [3:0]  dina;
    logic        front_page;
    logic        busy;
    logic        frame_done;
`ifdef DMD_FB_STATS_EN
    logic [15:0] frames_done;
    logic [15:0] sof_errors;
`endif

    dmd_fb_write_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .clr_req    (clr_req),
        .clr_value  (clr_value),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .front_page (front_page),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef DMD_FB_STATS_EN
        ,
        .frames_done(frames_done),
        .sof_errors (sof_errors)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level view of the spec) ----------------
    typedef enum {M_WAIT, M_RECV, M_FILL, M_HOLD} mphase_t;
    mphase_t     mph = M_WAIT;
    logic [12:0] q_addr[$];
    logic [3:0]  q_data[$];
    int          m_pix = 0;
    int          fill_left = 0;
    bit          hold_first = 0;
    bit          m_rdy = 0;
    bit          m_busy = 0;
    bit          m_front = 0;
    bit          m_fd = 0;
    int          m_frames = 0;
    int          m_sofe = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mph = M_WAIT; m_rdy = 0; m_busy = 0; m_front = 0; m_fd = 0;
            m_pix = 0; m_frames = 0; m_sofe = 0;
            q_addr.delete(); q_data.delete();
        end else begin
            bit acc;
            acc  = s_valid && m_rdy;
            m_fd = 0;
            case (mph)
                M_WAIT: begin
                    if (clr_req) begin
                        for (int i = 0; i < 4096; i++) begin
                            q_addr.push_back({~m_front, 12'(i)});
                            q_data.push_back(clr_value);
                        end
                        fill_left = 4096;
                        mph = M_FILL;
                    end else if (acc && s_sof) begin
                        q_addr.push_back({~m_front, 12'd0});
                        q_data.push_back(s_data);
                        m_pix = 1;
                        mph = M_RECV;
                    end
                end
                M_RECV: begin
                    if (acc) begin
                        if (s_sof) begin
                            q_addr.push_back({~m_front, 12'd0});
                            q_data.push_back(s_data);
                            m_pix = 1;
                            if (m_sofe < 65535) m_sofe++;
                        end else begin
                            q_addr.push_back({~m_front, 12'(m_pix)});
                            q_data.push_back(s_data);
                            m_pix++;
                            if (m_pix == 4096) begin
                                mph = M_HOLD; hold_first = 1;
                            end
                        end
                    end
                end
                M_FILL: begin
                    fill_left--;
                    if (fill_left == 0) begin
                        mph = M_HOLD; hold_first = 1;
                    end
                end
                M_HOLD: begin
                    if (hold_first) hold_first = 0;
                    else if (vsync) begin
                        m_front = ~m_front;
                        m_fd = 1;
                        m_frames = (m_frames + 1) % 65536;
                        mph = M_WAIT;
                    end
                end
            endcase
            m_rdy  = (mph == M_WAIT) || (mph == M_RECV);
            m_busy = (mph != M_WAIT);
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("s_ready", int'(s_ready), int'(m_rdy));
            chk("busy", int'(busy), int'(m_busy));
            chk("front_page", int'(front_page), int'(m_front));
            chk("frame_done", int'(frame_done), int'(m_fd));
`ifdef DMD_FB_STATS_EN
            chk("frames_done", int'(frames_done), m_frames);
            chk("sof_errors", int'(sof_errors), m_sofe);
`endif
            if (wea) begin
                if (q_addr.size() == 0) begin
                    chk("unexpected_write", int'(addra), -1);
                end else begin
                    logic [12:0] ea;
                    logic [3:0]  ed;
                    ea = q_addr.pop_front();
                    ed = q_data.pop_front();
                    chk("wr_addr", int'(addra), int'(ea));
                    chk("wr_data", int'(dina), int'(ed));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    bit stall_en = 0;

    task automatic beat(input logic sof, input logic [3:0] d);
        bit ok = 0;
        int n = 0;
        while (!ok) begin
            @(negedge clk);
            n++;
            if (n > 10000) begin
                chk("ready_timeout", 0, 1);
                ok = 1;
            end else if (stall_en && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0; s_sof = 1'b0;
            end else begin
                s_valid = 1'b1; s_sof = sof; s_data = d;
                ok = s_ready;
            end
        end
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge clk); vsync = 1'b1;
        @(negedge clk); vsync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        @(negedge clk) rst = 1'b0;
        // Reset state before the first clock edge after release.
        chk("rst_wea", int'(wea), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_front", int'(front_page), 0);
        chk("rst_addra", int'(addra), 0);
        idle(2);

        // 1: full frame, no stall, data = i%16
        stall_en = 0;
        for (int i = 0; i < 4096; i++) beat(i == 0, 4'(i % 16));
        drop();
        idle(5);
        pulse_vsync();
        idle(3);
        chk("t1_front", int'(front_page), 1);

        // 2: fill engine with 0x5, then swap
        @(negedge clk); clr_req = 1'b1; clr_value = 4'h5;
        @(negedge clk); clr_req = 1'b0; clr_value = 4'($urandom);
        chk("t2_s_ready", int'(s_ready), 0);
        idle(4100);
        pulse_vsync();
        idle(3);

        // 3: resync at pixel 100, random stalls and data
        stall_en = 1;
        for (int i = 0; i < 100; i++) beat(i == 0, 4'($urandom));
        beat(1'b1, 4'($urandom));
        for (int i = 1; i < 4096; i++) beat(1'b0, 4'($urandom));
        drop();
        idle(4);
        pulse_vsync();
        idle(3);

        // 4: non-sof beats in IDLE are accepted and dropped
        stall_en = 0;
        for (int i = 0; i < 6; i++) beat(1'b0, 4'($urandom));
        drop();
        idle(4);

        // 5: vsync coincident with the final write is ignored
        stall_en = 1;
        for (int i = 0; i < 4096; i++) beat(i == 0, 4'($urandom));
        @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0; vsync = 1'b1;
        chk("t5_last_wea", int'(wea), 1);
        @(negedge clk); vsync = 1'b0;
        idle(49);
        pulse_vsync();
        idle(3);

        // 6: reset mid-frame, then a clean frame
        stall_en = 0;
        for (int i = 0; i < 2000; i++) beat(i == 0, 4'($urandom));
        #2 rst = 1'b1;
        #1;
        chk("t6_wea_async", int'(wea), 0);
        chk("t6_front", int'(front_page), 0);
        @(negedge clk); s_valid = 1'b0; s_sof = 1'b0;
        @(negedge clk); rst = 1'b0;
        idle(2);
        stall_en = 1;
        for (int i = 0; i < 4096; i++) beat(i == 0, 4'($urandom));
        drop();
        idle(3);
        pulse_vsync();
        idle(3);
        chk("t6_front_after", int'(front_page), 1);

        idle(5);
        chk("queue_empty", q_addr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
